systolic_edge_feeder: RTL and testbench

- Transmit end of the systolic matrix-multiply array's data interface. It buffers operand matrices A (NxN) and B (NxN), then drives the array's left edge (A rows) and top edge (B columns) with the diagonal skew the PE mesh requires.
- It also generates the array clear pulse and signals when every PE Result holds C = A x B.
- Sits between the matrix-op register/load path and the PE mesh.

---
 rtl/systolic_edge_feeder_pkg.sv | 27 ++
 rtl/systolic_edge_feeder_if.sv | 42 ++++
 rtl/systolic_edge_feeder_skew_edge_mux.sv | 34 +++
 rtl/systolic_edge_feeder.sv | 147 ++++++++++++++
 tb/tb_systolic_edge_feeder.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_edge_feeder_pkg.sv
// Shared defaults, FSM state encoding and operand-select constants for the
// systolic array edge feeder.
package systolic_pkg;

  localparam int DEF_N  = 4;
  localparam int DEF_DW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } feeder_state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Index width for a range of n values, never narrower than one bit.
  function automatic int idx_w(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/systolic_edge_feeder_if.sv
// Load/control/edge bundle between the matrix-op load path, the feeder and the PE mesh.
// FEEDER_ERR_FLAG_EN adds the sticky Err flag.
interface systolic_edge_feeder_if #(
  parameter int N  = systolic_pkg::DEF_N,
  parameter int DW = systolic_pkg::DEF_DW
) ();
  import systolic_pkg::*;

  localparam int IW = idx_w(N);

  logic            Wr_En;
  logic            Wr_Sel;
  logic [IW-1:0]   Wr_Row;
  logic [IW-1:0]   Wr_Col;
  logic [DW-1:0]   Wr_Data;
  logic            Start;
  logic            Busy;
  logic            Done;
  logic            Pe_Clear;
  logic [N*DW-1:0] Left_Data;
  logic [N*DW-1:0] Top_Data;
`ifdef FEEDER_ERR_FLAG_EN
  logic            Err;
`endif

  modport master (
    output Wr_En, Wr_Sel, Wr_Row, Wr_Col, Wr_Data, Start,
`ifdef FEEDER_ERR_FLAG_EN
    input  Err,
`endif
    input  Busy, Done, Pe_Clear, Left_Data, Top_Data
  );

  modport slave (
    input  Wr_En, Wr_Sel, Wr_Row, Wr_Col, Wr_Data, Start,
`ifdef FEEDER_ERR_FLAG_EN
    output Err,
`endif
    output Busy, Done, Pe_Clear, Left_Data, Top_Data
  );

endinterface

// File: rtl/systolic_edge_feeder_skew_edge_mux.sv
// Diagonal-skew selector for one array edge: lane i gets A[i][t-i] (SEL_A)
// or B[t-i][i] (SEL_B), and zero outside the valid window.
module skew_edge_mux import systolic_pkg::*; #(
  parameter int   N   = DEF_N,
  parameter int   DW  = DEF_DW,
  parameter int   TW  = 2,
  parameter logic SEL = SEL_A
) (
  input  logic [TW-1:0]     t,
  input  logic [N*N*DW-1:0] buf_flat,
  output logic [N*DW-1:0]   edge_data
);

  int k_s;

  // Per-lane element select along the skewed diagonal
  always_comb begin
    edge_data = {(N*DW){1'b0}};
    k_s       = 0;
    for (int lane = 0; lane < N; lane++) begin
      k_s = int'(t) - lane;
      if ((k_s >= 0) && (k_s < N)) begin
        if (SEL == SEL_B) begin
          edge_data[lane*DW +: DW] = buf_flat[(k_s*N + lane)*DW +: DW];
        end else begin
          edge_data[lane*DW +: DW] = buf_flat[(lane*N + k_s)*DW +: DW];
        end
      end else begin
        edge_data[lane*DW +: DW] = {DW{1'b0}};
      end
    end
  end

endmodule

// File: rtl/systolic_edge_feeder.sv
// Operand buffer and skewed edge driver for an NxN systolic multiply array.
// Define FEEDER_ERR_FLAG_EN to add a sticky Err flag for Start/Wr_En while Busy.
module systolic_edge_feeder import systolic_pkg::*; #(
  parameter int N  = DEF_N,
  parameter int DW = DEF_DW
) (
  input  logic                   Clk,
  input  logic                   Reset,
  systolic_edge_feeder_if.slave  bus
);

  localparam int            TW     = idx_w(3*N);
  localparam logic [TW-1:0] T_LAST = TW'(3*N - 3);

  feeder_state_e     state_r, state_nxt_s;
  logic [TW-1:0]     t_r, t_nxt_s;
  logic              busy_r, done_r, pe_clear_r;
  logic [N*DW-1:0]   left_r, top_r, left_mux_s, top_mux_s;
  logic [N*N*DW-1:0] a_buf_r, b_buf_r;
  logic              start_ok_s, wr_ok_s;
  int                wr_idx_s;

  assign start_ok_s = bus.Start && (state_r == IDLE);
  assign wr_ok_s    = bus.Wr_En && ((state_r == IDLE) || (state_r == DONE)) &&
                      (int'(bus.Wr_Row) < N) && (int'(bus.Wr_Col) < N);
  assign wr_idx_s   = (int'(bus.Wr_Row) * N + int'(bus.Wr_Col)) * DW;

  // Operand buffers; kept across Reset on purpose
  always_ff @(posedge Clk) begin
    if (wr_ok_s) begin
      if (bus.Wr_Sel == SEL_B) begin
        b_buf_r[wr_idx_s +: DW] <= bus.Wr_Data;
      end else begin
        a_buf_r[wr_idx_s +: DW] <= bus.Wr_Data;
      end
    end
  end

  // Next state and step counter
  always_comb begin
    state_nxt_s = state_r;
    t_nxt_s     = t_r;
    case (state_r)
      IDLE: begin
        t_nxt_s = {TW{1'b0}};
        if (start_ok_s) begin
          state_nxt_s = CLEAR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CLEAR: begin
        state_nxt_s = STREAM;
        t_nxt_s     = {TW{1'b0}};
      end
      STREAM: begin
        if (t_r == T_LAST) begin
          state_nxt_s = DONE;
          t_nxt_s     = {TW{1'b0}};
        end else begin
          state_nxt_s = STREAM;
          t_nxt_s     = t_r + TW'(1);
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
        t_nxt_s     = {TW{1'b0}};
      end
      default: begin
        state_nxt_s = IDLE;
        t_nxt_s     = {TW{1'b0}};
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= IDLE;
      t_r     <= {TW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      t_r     <= t_nxt_s;
    end
  end

  // Muxes look one step ahead so the edges are registered for cycle t
  skew_edge_mux #(.N(N), .DW(DW), .TW(TW), .SEL(SEL_A)) u_left_mux (
    .t         (t_nxt_s),
    .buf_flat  (a_buf_r),
    .edge_data (left_mux_s)
  );

  skew_edge_mux #(.N(N), .DW(DW), .TW(TW), .SEL(SEL_B)) u_top_mux (
    .t         (t_nxt_s),
    .buf_flat  (b_buf_r),
    .edge_data (top_mux_s)
  );

  // Registered status and edge outputs, decoded from the next state
  always_ff @(posedge Clk) begin
    if (Reset) begin
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pe_clear_r <= 1'b0;
      left_r     <= {(N*DW){1'b0}};
      top_r      <= {(N*DW){1'b0}};
    end else begin
      busy_r     <= (state_nxt_s == CLEAR) || (state_nxt_s == STREAM);
      done_r     <= (state_nxt_s == DONE);
      pe_clear_r <= (state_nxt_s == CLEAR);
      if (state_nxt_s == STREAM) begin
        left_r <= left_mux_s;
        top_r  <= top_mux_s;
      end else begin
        left_r <= {(N*DW){1'b0}};
        top_r  <= {(N*DW){1'b0}};
      end
    end
  end

  assign bus.Busy      = busy_r;
  assign bus.Done      = done_r;
  assign bus.Pe_Clear  = pe_clear_r;
  assign bus.Left_Data = left_r;
  assign bus.Top_Data  = top_r;

`ifdef FEEDER_ERR_FLAG_EN
  logic err_r;

  // Sticky flag for traffic arriving while the array is being driven
  always_ff @(posedge Clk) begin
    if (Reset) begin
      err_r <= 1'b0;
    end else if (start_ok_s) begin
      err_r <= 1'b0;
    end else if ((bus.Start || bus.Wr_En) && busy_r) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign bus.Err = err_r;
`endif

endmodule

// File: tb/tb_systolic_edge_feeder.sv
// Directed bench for systolic_edge_feeder: N=4, N=2 and N=1 instances, each
// driving a behavioural PE mesh whose results are compared with a reference product.
module tb_systolic_edge_feeder;
  import systolic_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  systolic_edge_feeder_if #(.N(4), .DW(32)) if4 ();
  systolic_edge_feeder_if #(.N(2), .DW(32)) if2 ();
  systolic_edge_feeder_if #(.N(1), .DW(32)) if1 ();

  systolic_edge_feeder #(.N(4), .DW(32)) u_dut4 (.Clk(clk), .Reset(rst), .bus(if4));
  systolic_edge_feeder #(.N(2), .DW(32)) u_dut2 (.Clk(clk), .Reset(rst), .bus(if2));
  systolic_edge_feeder #(.N(1), .DW(32)) u_dut1 (.Clk(clk), .Reset(rst), .bus(if1));

  logic [127:0] left_v [3];
  logic [127:0] top_v  [3];
  logic         busy_v [3];
  logic         done_v [3];
  logic         pclr_v [3];

  assign left_v[0] = if4.Left_Data;
  assign left_v[1] = {64'd0, if2.Left_Data};
  assign left_v[2] = {96'd0, if1.Left_Data};
  assign top_v[0]  = if4.Top_Data;
  assign top_v[1]  = {64'd0, if2.Top_Data};
  assign top_v[2]  = {96'd0, if1.Top_Data};
  assign busy_v[0] = if4.Busy;
  assign busy_v[1] = if2.Busy;
  assign busy_v[2] = if1.Busy;
  assign done_v[0] = if4.Done;
  assign done_v[1] = if2.Done;
  assign done_v[2] = if1.Done;
  assign pclr_v[0] = if4.Pe_Clear;
  assign pclr_v[1] = if2.Pe_Clear;
  assign pclr_v[2] = if1.Pe_Clear;

  longint unsigned acc [3][4][4];
  logic [31:0]     ah  [3][4][4];
  logic [31:0]     bv  [3][4][4];
  int unsigned     am  [3][4][4];
  int unsigned     bm  [3][4][4];
  int              done_cnt [3] = '{0, 0, 0};
  int              pclr_cnt [3] = '{0, 0, 0};
  int              skew_l [4] = '{3, 12, 21, 30};
  int              skew_t [4] = '{130, 121, 112, 103};
  int              id_exp [4] = '{5, 6, 7, 8};
  int              lat;

  function automatic int n_of(input int k);
    case (k)
      0:       return 4;
      1:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic logic [31:0] a_in(input int k, input int i, input int j);
    if (j == 0) return left_v[k][i*32 +: 32];
    else        return ah[k][i][j-1];
  endfunction

  function automatic logic [31:0] b_in(input int k, input int i, input int j);
    if (i == 0) return top_v[k][j*32 +: 32];
    else        return bv[k][i-1][j];
  endfunction

  // Behavioural PE mesh: A moves right, B moves down, unconditional accumulate
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < n_of(k); i++) begin
        for (int j = 0; j < n_of(k); j++) begin
          if (pclr_v[k]) begin
            acc[k][i][j] <= 64'd0;
            ah[k][i][j]  <= 32'd0;
            bv[k][i][j]  <= 32'd0;
          end else begin
            acc[k][i][j] <= acc[k][i][j] + ({32'd0, a_in(k, i, j)} * {32'd0, b_in(k, i, j)});
            ah[k][i][j]  <= a_in(k, i, j);
            bv[k][i][j]  <= b_in(k, i, j);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (done_v[k] === 1'b1) done_cnt[k] <= done_cnt[k] + 1;
      if (pclr_v[k] === 1'b1) pclr_cnt[k] <= pclr_cnt[k] + 1;
    end
  end

  function automatic longint unsigned ref_c(input int k, input int i, input int j);
    longint unsigned s = 64'd0;
    for (int m = 0; m < n_of(k); m++) s += 64'(am[k][i][m]) * 64'(bm[k][m][j]);
    return s;
  endfunction

  task automatic check_val(input string tag, input longint unsigned got, input longint unsigned exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic st, input logic en, input logic sel,
                       input int row, input int col, input logic [31:0] d);
    case (k)
      0: begin
        if4.Start = st; if4.Wr_En = en; if4.Wr_Sel = sel;
        if4.Wr_Row = row[1:0]; if4.Wr_Col = col[1:0]; if4.Wr_Data = d;
      end
      1: begin
        if2.Start = st; if2.Wr_En = en; if2.Wr_Sel = sel;
        if2.Wr_Row = row[0:0]; if2.Wr_Col = col[0:0]; if2.Wr_Data = d;
      end
      default: begin
        if1.Start = st; if1.Wr_En = en; if1.Wr_Sel = sel;
        if1.Wr_Row = row[0:0]; if1.Wr_Col = col[0:0]; if1.Wr_Data = d;
      end
    endcase
  endtask

  task automatic wr(input int k, input logic sel, input int row, input int col, input int unsigned d);
    drive(k, 1'b0, 1'b1, sel, row, col, d);
    if (sel == SEL_B) bm[k][row][col] = d;
    else              am[k][row][col] = d;
    tick();
    drive(k, 1'b0, 1'b0, 1'b0, 0, 0, 32'd0);
  endtask

  task automatic check_mesh(input int k);
    for (int i = 0; i < n_of(k); i++)
      for (int j = 0; j < n_of(k); j++)
        check_val($sformatf("c%0d_%0d%0d", k, i, j), acc[k][i][j], ref_c(k, i, j));
  endtask

  // mode: 0 plain, 1 skew checks, 2 N=1 stream, 3 illegal traffic, 4 reset mid-stream
  task automatic run(input int k, input int mode, output int lat_o);
    int d0, p0;
    d0 = done_cnt[k];
    p0 = pclr_cnt[k];
    lat_o = -1;
    drive(k, 1'b1, 1'b0, 1'b0, 0, 0, 32'd0);
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (c == 1) drive(k, 1'b0, 1'b0, 1'b0, 0, 0, 32'd0);
      if (mode == 1 && c == 5) begin
        for (int i = 0; i < 4; i++) begin
          check_val($sformatf("skew_left%0d", i), left_v[0][i*32 +: 32], skew_l[i]);
          check_val($sformatf("skew_top%0d", i), top_v[0][i*32 +: 32], skew_t[i]);
        end
      end
      if (mode == 1 && c >= 9 && c <= 11)
        check_val($sformatf("flush_zero_t%0d", c - 2), {63'd0, (|left_v[0]) | (|top_v[0])}, 0);
      if (mode == 2 && c == 2) begin
        check_val("n1_left", left_v[2][31:0], 3);
        check_val("n1_top", top_v[2][31:0], 4);
      end
      if (mode == 3 && c == 4) drive(k, 1'b1, 1'b1, SEL_A, 0, 0, 32'd99);
      if (mode == 3 && c == 5) drive(k, 1'b0, 1'b0, 1'b0, 0, 0, 32'd0);
`ifdef FEEDER_ERR_FLAG_EN
      if (mode == 3 && c == 6) check_val("err_set", if4.Err, 1);
`endif
      if (mode == 4 && c == 7) rst = 1'b1;
      if (mode == 4 && c == 8) begin
        check_val("mid_rst_busy", busy_v[k], 0);
        check_val("mid_rst_pclr", pclr_v[k], 0);
        check_val("mid_rst_done", done_v[k], 0);
        check_val("mid_rst_edges", {63'd0, (|left_v[k]) | (|top_v[k])}, 0);
`ifdef FEEDER_ERR_FLAG_EN
        check_val("mid_rst_err", if4.Err, 0);
`endif
        rst = 1'b0;
        break;
      end
      if (done_v[k] === 1'b1) begin
        lat_o = c;
        break;
      end
    end
    if (mode == 4) begin
      repeat (20) tick();
      check_val("mid_rst_no_done", done_cnt[k] - d0, 0);
    end else begin
      tick();
      check_val("done_one_cycle", done_v[k], 0);
      check_val("done_pulses", done_cnt[k] - d0, 1);
      check_val("pclr_pulses", pclr_cnt[k] - p0, 1);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) drive(k, 1'b0, 1'b0, 1'b0, 0, 0, 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("rst_busy%0d", k), busy_v[k], 0);
      check_val($sformatf("rst_done%0d", k), done_v[k], 0);
      check_val($sformatf("rst_pclr%0d", k), pclr_v[k], 0);
      check_val($sformatf("rst_left%0d", k), left_v[k][63:0], 0);
      check_val($sformatf("rst_top%0d", k), top_v[k][63:0], 0);
    end
`ifdef FEEDER_ERR_FLAG_EN
    check_val("rst_err", if4.Err, 0);
`endif

    // N=4 skew pattern
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        wr(0, SEL_A, i, j, 10*i + j);
        wr(0, SEL_B, i, j, 100 + 10*i + j);
      end
    run(0, 1, lat);
    check_val("n4_skew_lat", lat, 12);
    check_mesh(0);

    // N=4 random operands, with illegal Start/write mid-stream
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        wr(0, SEL_A, i, j, $urandom_range(0, 255));
        wr(0, SEL_B, i, j, $urandom_range(0, 255));
      end
    wr(0, SEL_A, 0, 0, 7);
    run(0, 3, lat);
    check_val("n4_illegal_lat", lat, 12);
    check_mesh(0);
`ifdef FEEDER_ERR_FLAG_EN
    check_val("err_sticky", if4.Err, 1);
`endif
    run(0, 0, lat);
    check_val("n4_rerun_lat", lat, 12);
    check_mesh(0);
`ifdef FEEDER_ERR_FLAG_EN
    check_val("err_cleared", if4.Err, 0);
`endif

    // Reset mid-stream then normal restart
    run(0, 4, lat);
    run(0, 0, lat);
    check_val("n4_after_rst_lat", lat, 12);
    check_mesh(0);

    // N=2 identity
    wr(1, SEL_A, 0, 0, 1); wr(1, SEL_A, 0, 1, 0); wr(1, SEL_A, 1, 0, 0); wr(1, SEL_A, 1, 1, 1);
    wr(1, SEL_B, 0, 0, 5); wr(1, SEL_B, 0, 1, 6); wr(1, SEL_B, 1, 0, 7); wr(1, SEL_B, 1, 1, 8);
    run(1, 0, lat);
    check_val("n2_lat", lat, 6);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        check_val($sformatf("n2_c%0d%0d", i, j), acc[1][i][j], id_exp[i*2 + j]);

    // N=1
    wr(2, SEL_A, 0, 0, 3);
    wr(2, SEL_B, 0, 0, 4);
    run(2, 2, lat);
    check_val("n1_lat", lat, 3);
    check_val("n1_result", acc[2][0][0], 12);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
